// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles every signal between the single-port data memory arbiter, its two
//   requesters (instruction fetch and MEM stage) and the memory itself.
//
//   Signal groups:
//     if_*            fetch requester: req/address in, ready/valid/rdata out
//     dm_*            data requester: req/write/address/wdata in,
//                     ready/valid/rdata out
//     mem_*           memory side: read/write strobes, address, wdata out;
//                     rdata in
//     stall_*         per-stage stall indications for the hazard logic
//     conflict_count  saturating count of cycles with both requests present
//
//   Modports:
//     slave  - the arbiter's view
//     master - the view of the pipeline and memory around the arbiter
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  // Fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_address;
  logic              if_ready;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  // Data requester
  logic              dm_req;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;

  // Memory port
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Hazard / statistics
  logic              stall_fetch;
  logic              stall_mem;
  logic [CNT_W-1:0]  conflict_count;

  modport slave (
    input  if_req, if_address,
    input  dm_req, dm_write, dm_address, dm_wdata,
    input  mem_rdata,
    output if_ready, if_valid, if_rdata,
    output dm_ready, dm_valid, dm_rdata,
    output mem_read, mem_write, mem_address, mem_wdata,
    output stall_fetch, stall_mem, conflict_count
  );

  modport master (
    output if_req, if_address,
    output dm_req, dm_write, dm_address, dm_wdata,
    output mem_rdata,
    input  if_ready, if_valid, if_rdata,
    input  dm_ready, dm_valid, dm_rdata,
    input  mem_read, mem_write, mem_address, mem_wdata,
    input  stall_fetch, stall_mem, conflict_count
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port data memory between instruction fetch and the MEM
//   stage. One access is granted per cycle; data wins unless fetch has been
//   passed over MAX_DATA_RUN times in a row, in which case fetch is forced.
//   Accepted reads are tracked by a {valid, owner} tag pipeline whose depth
//   equals the memory read latency, so returning data is flagged on the
//   correct requester's valid.
//
//   Ports:
//     clock  - system clock, rising edge
//     reset  - asynchronous, active-low reset
//     bus    - mem_port_arbiter_if.slave (fetch, data, memory, stall and
//              statistics signals)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,   // 1..4
  parameter int MAX_DATA_RUN = 3,
  parameter int CNT_W        = 16
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int RUN_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_DATA
  } grant_e;

  grant_e                  w_grant;
  logic                    w_force_if;
  logic [RUN_W-1:0]        r_run_cnt;
  logic [READ_LATENCY-1:0] r_tag_valid;
  logic [READ_LATENCY-1:0] r_tag_owner;   // 0 = fetch, 1 = data
  logic [CNT_W-1:0]        r_conflict_cnt;

  // -------------------------------------------------------------------------
  // Grant selection. Held at "no grant" while reset is asserted so that the
  // ready and strobe outputs are quiet during reset.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a signal unassigned would otherwise infer a latch.
    w_grant    = GNT_NONE;
    w_force_if = bus.if_req && (r_run_cnt == RUN_MAX);
    if (reset) begin
      if (bus.dm_req && !w_force_if) w_grant = GNT_DATA;
      else if (bus.if_req)           w_grant = GNT_FETCH;
    end
  end

  // -------------------------------------------------------------------------
  // Memory drive and handshakes
  // -------------------------------------------------------------------------
  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    unique case (w_grant)
      GNT_DATA: begin
        bus.mem_address = bus.dm_address;
        bus.mem_read    = !bus.dm_write;
        bus.mem_write   = bus.dm_write;
        bus.mem_wdata   = bus.dm_wdata;
      end
      GNT_FETCH: begin
        bus.mem_address = bus.if_address;
        bus.mem_read    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.if_ready    = (w_grant == GNT_FETCH);
  assign bus.dm_ready    = (w_grant == GNT_DATA);
  assign bus.stall_fetch = bus.if_req && !bus.if_ready;
  assign bus.stall_mem   = bus.dm_req && !bus.dm_ready;

  // -------------------------------------------------------------------------
  // Run counter: consecutive data grants while fetch is waiting. Reaching
  // RUN_MAX forces the next grant to fetch.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      r_run_cnt <= '0;
    end else if (!bus.if_req || (w_grant == GNT_FETCH)) begin
      r_run_cnt <= '0;
    end else if ((w_grant == GNT_DATA) && (r_run_cnt != RUN_MAX)) begin
      r_run_cnt <= r_run_cnt + RUN_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Read tag pipeline. Stage 0 records whether a read was issued this cycle
  // and who owns it; the last stage lines up with mem_rdata.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tag_valid <= '0;
      r_tag_owner <= '0;
    end else begin
      r_tag_valid[0] <= bus.mem_read;
      r_tag_owner[0] <= (w_grant == GNT_DATA);
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_owner[i] <= r_tag_owner[i-1];
      end
    end
  end

  assign bus.if_valid = r_tag_valid[READ_LATENCY-1] && !r_tag_owner[READ_LATENCY-1];
  assign bus.dm_valid = r_tag_valid[READ_LATENCY-1] &&  r_tag_owner[READ_LATENCY-1];
  assign bus.if_rdata = bus.mem_rdata;
  assign bus.dm_rdata = bus.mem_rdata;

  // -------------------------------------------------------------------------
  // Conflict counter, saturating at all-ones
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_conflict_cnt <= '0;
    end else if (bus.if_req && bus.dm_req && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign bus.conflict_count = r_conflict_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Three arbiter instances (READ_LATENCY 1, 2, 3; CNT_W 4) share one set of
//   requester inputs. Each has its own small word-addressed memory model with
//   the matching read latency; word i initially holds the value i.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NI = 3;

  logic clock;
  logic reset;

  logic          if_req;
  logic [AW-1:0] if_address;
  logic          dm_req;
  logic          dm_write;
  logic [AW-1:0] dm_address;
  logic [DW-1:0] dm_wdata;

  logic [NI-1:0] w_if_ready, w_dm_ready, w_if_valid, w_dm_valid;
  logic [NI-1:0] w_mem_read, w_mem_write, w_stall_fetch, w_stall_mem;
  logic [AW-1:0] w_mem_address [NI];
  logic [DW-1:0] w_mem_wdata   [NI];
  logic [DW-1:0] w_if_rdata    [NI];
  logic [DW-1:0] w_dm_rdata    [NI];
  logic [CW-1:0] w_conflict    [NI];

  int n_checks = 0;
  int n_errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) u_bus ();

    assign u_bus.if_req     = if_req;
    assign u_bus.if_address = if_address;
    assign u_bus.dm_req     = dm_req;
    assign u_bus.dm_write   = dm_write;
    assign u_bus.dm_address = dm_address;
    assign u_bus.dm_wdata   = dm_wdata;

    mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(g + 1),
      .MAX_DATA_RUN(3), .CNT_W(CW)
    ) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (u_bus.slave)
    );

    // Memory model with READ_LATENCY = g+1
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] rd_pipe [0:g];
    logic [7:0]    idx;
    assign idx = u_bus.mem_address[9:2];

    initial for (int i = 0; i < 256; i++) mem[i] = DW'(i);

    always @(posedge clock) begin
      if (u_bus.mem_write) mem[idx] <= u_bus.mem_wdata;
      rd_pipe[0] <= mem[idx];
      for (int j = 1; j <= g; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign u_bus.mem_rdata = rd_pipe[g];

    assign w_if_ready[g]    = u_bus.if_ready;
    assign w_dm_ready[g]    = u_bus.dm_ready;
    assign w_if_valid[g]    = u_bus.if_valid;
    assign w_dm_valid[g]    = u_bus.dm_valid;
    assign w_mem_read[g]    = u_bus.mem_read;
    assign w_mem_write[g]   = u_bus.mem_write;
    assign w_stall_fetch[g] = u_bus.stall_fetch;
    assign w_stall_mem[g]   = u_bus.stall_mem;
    assign w_mem_address[g] = u_bus.mem_address;
    assign w_mem_wdata[g]   = u_bus.mem_wdata;
    assign w_if_rdata[g]    = u_bus.if_rdata;
    assign w_dm_rdata[g]    = u_bus.dm_rdata;
    assign w_conflict[g]    = u_bus.conflict_count;
  end

  typedef struct {
    logic          ifr;
    logic [AW-1:0] ifa;
    logic          dmr;
    logic          dmw;
    logic [AW-1:0] dma;
    logic [DW-1:0] dmwd;
    logic          e_ifrdy;
    logic          e_dmrdy;
    logic          e_mrd;
    logic          e_mwr;
    logic [AW-1:0] e_maddr;
    logic          e_ifv;
    logic          e_dmv;
    logic [DW-1:0] e_rdata;
    logic          e_stf;
    logic          e_stm;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(
    input logic ifr, input logic [AW-1:0] ifa,
    input logic dmr, input logic dmw, input logic [AW-1:0] dma, input logic [DW-1:0] dmwd,
    input logic e_ifrdy, input logic e_dmrdy, input logic e_mrd, input logic e_mwr,
    input logic [AW-1:0] e_maddr, input logic e_ifv, input logic e_dmv,
    input logic [DW-1:0] e_rdata, input logic e_stf, input logic e_stm);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dmw = dmw; v.dma = dma; v.dmwd = dmwd;
    v.e_ifrdy = e_ifrdy; v.e_dmrdy = e_dmrdy; v.e_mrd = e_mrd; v.e_mwr = e_mwr;
    v.e_maddr = e_maddr; v.e_ifv = e_ifv; v.e_dmv = e_dmv; v.e_rdata = e_rdata;
    v.e_stf = e_stf; v.e_stm = e_stm;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic [AW-1:0] ifa, input logic dmr,
                       input logic dmw, input logic [AW-1:0] dma, input logic [DW-1:0] dmwd);
    if_req = ifr; if_address = ifa;
    dm_req = dmr; dm_write = dmw; dm_address = dma; dm_wdata = dmwd;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Expected valids/data for the alternating READ_LATENCY=3 sequence
  logic       t5_ifv [8];
  logic       t5_dmv [8];
  logic [31:0] t5_dat [8];

  initial begin
    // ---- table: fetch stream, write/read-back, contention ----
    vecs[0]  = mk(1, 'h00, 0, 0, 'h00, 0,          1, 0, 1, 0, 'h00, 0, 0, 0,          0, 0);
    vecs[1]  = mk(1, 'h04, 0, 0, 'h00, 0,          1, 0, 1, 0, 'h04, 1, 0, 0,          0, 0);
    vecs[2]  = mk(1, 'h08, 0, 0, 'h00, 0,          1, 0, 1, 0, 'h08, 1, 0, 1,          0, 0);
    vecs[3]  = mk(0, 'h00, 0, 0, 'h00, 0,          0, 0, 0, 0, 'h00, 1, 0, 2,          0, 0);
    vecs[4]  = mk(0, 'h00, 1, 1, 'h40, 'hDEADBEEF, 0, 1, 0, 1, 'h40, 0, 0, 0,          0, 0);
    vecs[5]  = mk(0, 'h00, 1, 0, 'h40, 0,          0, 1, 1, 0, 'h40, 0, 0, 0,          0, 0);
    vecs[6]  = mk(0, 'h00, 0, 0, 'h00, 0,          0, 0, 0, 0, 'h00, 0, 1, 'hDEADBEEF, 0, 0);
    vecs[7]  = mk(1, 'h10, 1, 0, 'h20, 0,          0, 1, 1, 0, 'h20, 0, 0, 0,          1, 0);
    vecs[8]  = mk(1, 'h10, 1, 0, 'h20, 0,          0, 1, 1, 0, 'h20, 0, 1, 8,          1, 0);
    vecs[9]  = mk(1, 'h10, 1, 0, 'h20, 0,          0, 1, 1, 0, 'h20, 0, 1, 8,          1, 0);
    vecs[10] = mk(1, 'h10, 1, 0, 'h20, 0,          1, 0, 1, 0, 'h10, 0, 1, 8,          0, 1);
    vecs[11] = mk(1, 'h10, 1, 0, 'h20, 0,          0, 1, 1, 0, 'h20, 1, 0, 4,          1, 0);
    vecs[12] = mk(1, 'h10, 1, 0, 'h20, 0,          0, 1, 1, 0, 'h20, 0, 1, 8,          1, 0);
    vecs[13] = mk(0, 'h00, 0, 0, 'h00, 0,          0, 0, 0, 0, 'h00, 0, 1, 8,          0, 0);

    for (int k = 0; k < 8; k++) begin
      t5_ifv[k] = 1'b0; t5_dmv[k] = 1'b0; t5_dat[k] = '0;
    end
    t5_ifv[3] = 1'b1; t5_dat[3] = 32'd1;
    t5_dmv[4] = 1'b1; t5_dat[4] = 32'd3;
    t5_ifv[5] = 1'b1; t5_dat[5] = 32'd2;
    t5_dmv[6] = 1'b1; t5_dat[6] = 32'd5;

    // ---- reset state, with both requests asserted ----
    reset = 1'b0;
    drive(1, 'h100, 1, 1, 'h200, 'h55);
    @(negedge clock);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst%0d ready", g), {w_if_ready[g], w_dm_ready[g]}, 2'b00);
      check($sformatf("rst%0d strobes", g), {w_mem_read[g], w_mem_write[g]}, 2'b00);
      check($sformatf("rst%0d addr/wdata", g), {w_mem_address[g], w_mem_wdata[g]}, 64'h0);
      check($sformatf("rst%0d valids", g), {w_if_valid[g], w_dm_valid[g]}, 2'b00);
      check($sformatf("rst%0d conflict", g), w_conflict[g], 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    reset = 1'b1;

    // ---- reset mid-run with two reads in flight (READ_LATENCY=2) ----
    drive(1, 'h00, 0, 0, 'h00, 0);
    next_cycle();
    drive(1, 'h00, 1, 0, 'h04, 0);   // data wins, one conflict cycle
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("midrst c%0d valids", k), {w_if_valid[1], w_dm_valid[1]}, 2'b00);
      check($sformatf("midrst c%0d conflict", k), w_conflict[1], 0);
      next_cycle();
    end

    // ---- table-driven vectors on the READ_LATENCY=1 instance ----
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].ifr, vecs[i].ifa, vecs[i].dmr, vecs[i].dmw, vecs[i].dma, vecs[i].dmwd);
      @(negedge clock);
      check($sformatf("v%0d ready", i), {w_if_ready[0], w_dm_ready[0]},
            {vecs[i].e_ifrdy, vecs[i].e_dmrdy});
      check($sformatf("v%0d strobes", i), {w_mem_read[0], w_mem_write[0]},
            {vecs[i].e_mrd, vecs[i].e_mwr});
      check($sformatf("v%0d mem_address", i), w_mem_address[0], vecs[i].e_maddr);
      check($sformatf("v%0d valids", i), {w_if_valid[0], w_dm_valid[0]},
            {vecs[i].e_ifv, vecs[i].e_dmv});
      check($sformatf("v%0d stalls", i), {w_stall_fetch[0], w_stall_mem[0]},
            {vecs[i].e_stf, vecs[i].e_stm});
      if (vecs[i].e_mwr) check($sformatf("v%0d mem_wdata", i), w_mem_wdata[0], vecs[i].dmwd);
      if (vecs[i].e_ifv) check($sformatf("v%0d if_rdata", i), w_if_rdata[0], vecs[i].e_rdata);
      if (vecs[i].e_dmv) check($sformatf("v%0d dm_rdata", i), w_dm_rdata[0], vecs[i].e_rdata);
      next_cycle();
    end
    check("conflict after contention", w_conflict[0], 6);

    // drain the deeper pipelines
    for (int k = 0; k < 4; k++) next_cycle();

    // ---- alternating fetch/data reads, READ_LATENCY=3 ----
    for (int k = 0; k < 8; k++) begin
      case (k)
        0:       drive(1, 'h04, 0, 0, 'h00, 0);
        1:       drive(0, 'h00, 1, 0, 'h0C, 0);
        2:       drive(1, 'h08, 0, 0, 'h00, 0);
        3:       drive(0, 'h00, 1, 0, 'h14, 0);
        default: drive(0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clock);
      check($sformatf("lat3 c%0d valids", k), {w_if_valid[2], w_dm_valid[2]},
            {t5_ifv[k], t5_dmv[k]});
      if (t5_ifv[k]) check($sformatf("lat3 c%0d if_rdata", k), w_if_rdata[2], t5_dat[k]);
      if (t5_dmv[k]) check($sformatf("lat3 c%0d dm_rdata", k), w_dm_rdata[2], t5_dat[k]);
      next_cycle();
    end

    // ---- conflict counter saturation (CNT_W=4) ----
    drive(1, 'h00, 1, 0, 'h00, 0);
    for (int k = 0; k < (1 << CW) + 5; k++) next_cycle();
    @(negedge clock);
    check("conflict saturated", w_conflict[0], {CW{1'b1}});
    check("conflict saturated lat3", w_conflict[2], {CW{1'b1}});
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
